// File: rtl/sram_port_ctrl_pkg.sv
// Shared types and default sizes for the SRAM port controller.
// Imported by the controller top and its response FIFO.
package sram_port_ctrl_pkg;

  localparam int DEPTH_DEF      = 4096;
  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 64;
  localparam int RESP_DEPTH_DEF = 3;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Count width able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Small synchronous FIFO buffering SRAM read data for the consumer.
// Head entry is presented combinationally; count reports occupancy.
module sram_resp_fifo
  import sram_port_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = RESP_DEPTH_DEF,
  parameter int CNT_W  = cnt_width(RESP_DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Front-end for a single-port RW SRAM: clear sweep, read/write
// arbitration and a credit-managed read response queue.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = cnt_width(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(RESP_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              inflight_q, inflight_d;
  logic              rr_q, rr_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    used;
  logic              rd_ok;
  logic              rd_go;
  logic              conflict;
  logic              grant_wr;
  logic              grant_rd;
  logic              fire_wr;
  logic              fire_rd;
  logic              pop;

  // Credit check from registered terms only.
  always_comb begin
    used  = {1'b0, count} + (CNT_W + 1)'(inflight_q);
    rd_ok = used < CREDITS;
  end

  // FSM next-state, clear sweep and arbitration.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    init_done = 1'b0;
    conflict  = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    rd_go     = rd_valid && rd_ok;
    unique case (state_q)
      BOOT: begin
        state_d = INIT;
      end
      INIT: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
        unique case (1'b1)
          (wr_valid && rd_go): begin
            conflict = 1'b1;
            grant_wr = !rr_q;
            grant_rd = rr_q;
          end
          (wr_valid && !rd_go): grant_wr = 1'b1;
          (!wr_valid && rd_go): grant_rd = 1'b1;
          default: ;
        endcase
      end
      default: state_d = BOOT;
    endcase
  end

  // Handshakes and next values for the round-robin and inflight flags.
  always_comb begin
    wr_ready   = grant_wr;
    rd_ready   = grant_rd;
    fire_wr    = wr_valid && wr_ready;
    fire_rd    = rd_valid && rd_ready;
    rr_d       = conflict ? !rr_q : rr_q;
    inflight_d = fire_rd;
    pop        = resp_valid && resp_ready;
  end

  // Macro pin drive: sweep writes zeros, otherwise the granted request.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state_q == INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = clr_cnt_q;
    end else begin
      sram_en    = fire_wr || fire_rd;
      sram_wmode = fire_wr;
      if (fire_wr) begin
        sram_addr  = wr_addr;
        sram_wdata = wr_data;
      end else if (fire_rd) begin
        sram_addr  = rd_addr;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      clr_cnt_q  <= '0;
      inflight_q <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
    end
  end

  sram_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH),
    .CNT_W  (CNT_W)
  ) u_resp_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .push      (inflight_q),
    .push_data (sram_rdata),
    .pop       (pop),
    .head_data (resp_data),
    .count     (count)
  );

  assign resp_valid = (count != '0);

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Front-end controller for the single-port 4096×64 RW SRAM macro (1-cycle registered read, no read-during-write).
- Clears every entry to zero after reset.
- Arbitrates independent valid/ready read and write request streams onto the macro's single RW port.
- Captures read data into a response queue with backpressure, so downstream consumers never see the macro's volatile read port.
- Sits directly upstream of the macro; drives its RW0_* pins.

## Interface
- DEPTH, 4096, number of SRAM entries
- ADDR_W, 12, address width, log2(DEPTH)
- DATA_W, 64, data width
- RESP_DEPTH, 3, response queue entries
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wr_valid / wr_ready  in/out  1  write request handshake
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_valid / rd_ready  in/out  1  read request handshake
- rd_addr  in  ADDR_W  read address
- resp_valid / resp_ready  out/in  1  read response handshake
- resp_data  out  DATA_W  read data, in request order
- init_done  out  1  high once clear sweep is finished
- sram_en, sram_wmode  out  1  macro RW0_en / RW0_wmode
- sram_addr  out  ADDR_W  macro RW0_addr
- sram_wdata  out  DATA_W  macro RW0_wdata
- sram_rdata  in  DATA_W  macro RW0_rdata

## Operation
- FSM states:
  - BOOT: reset state; sram_en=0.
  - INIT: clear sweep; sram_en=1, sram_wmode=1, sram_wdata=0, sram_addr=clr_cnt; clr_cnt increments each cycle.
  - RUN: normal operation.
- FSM transitions:
  - BOOT→INIT on the first edge after reset release.
  - INIT→RUN on the edge where clr_cnt==DEPTH-1.
  - RUN is terminal.
- Signals in BOOT/INIT: wr_ready=0, rd_ready=0, init_done=0.
- Signals in RUN: init_done=1.
- Read credit:
  - rd_ok = (count + inflight) < RESP_DEPTH.
  - inflight is a 1-bit flag for a read issued in the previous cycle.
  - rd_ok uses registered terms only; no combinational path from resp_ready.
- Arbitration (RUN only):
  - Only write valid → write granted.
  - Only read valid and rd_ok → read granted.
  - Both valid and rd_ok → grant goes to the side selected by round-robin bit rr (reset 0 = write first).
  - rr toggles only on a conflict grant.
  - Read valid but !rd_ok → write may still be granted.
- Handshake:
  - wr_ready = RUN && grant_wr. rd_ready = RUN && grant_rd.
  - Grants are computed from valids combinationally; ready may depend on the other stream's valid.
- SRAM drive (combinational):
  - sram_en = fire_wr | fire_rd.
  - sram_wmode = fire_wr.
  - sram_addr / sram_wdata muxed from the winner.
  - sram_wdata = 0 when not writing.
- Read return:
  - A read fired in cycle t sets inflight.
  - In cycle t+1, sram_rdata is pushed into the response queue.
  - Queue is FIFO; resp_valid = count!=0; resp_data = head entry.
- Ordering: requests hit the SRAM in grant order. A write fired at t is visible to a read fired at t+1 or later.
- Width rules:
  - count is 0..RESP_DEPTH, 2 bits.
  - clr_cnt is ADDR_W bits and wraps to 0 on exit (unused afterwards).

## Timing
- Reset values: state=BOOT, clr_cnt=0, inflight=0, count=0, rr=0.
- Output values in reset: resp_valid=0, wr_ready=0, rd_ready=0, init_done=0, sram_en=0.
- Clear sweep:
  - Cycle 0 after release = BOOT.
  - Cycles 1..DEPTH = INIT.
  - init_done=1 from cycle DEPTH+1.
- Read latency: rd handshake in cycle t → resp_valid at earliest in cycle t+2.
- Throughput: one read per cycle sustained while resp_ready=1.
- Queue full:
  - count + inflight == RESP_DEPTH → rd_ready=0.
  - Writes are unaffected.
- Simultaneous push and pop: count unchanged, no data lost. Pop from an empty queue cannot occur.
- Mid-operation reset (reset_n low at any point):
  - Aborts immediately: queue emptied, inflight dropped, FSM→BOOT.
  - The full clear sweep reruns after release.

## Structure
- Package sram_port_ctrl_pkg holds:
  - state enum {BOOT, INIT, RUN};
  - RESP_DEPTH default;
  - ADDR_W/DATA_W defaults.
- One sub-module: sram_resp_fifo, a RESP_DEPTH-entry synchronous FIFO with count output.
- Arbitration and FSM stay in the top module.

## Test plan
- Reset release, no traffic:
  - exactly 4096 consecutive write cycles with wdata=0, addresses 0..4095;
  - init_done rises at cycle 4097;
  - rd_ready=wr_ready=0 before that.
- Write 0x0123_4567_89AB_CDEF @0x005, then read 0x005 next cycle:
  - resp_data=0x0123_4567_89AB_CDEF two cycles after the read handshake;
  - unwritten 0x006 reads 0.
- Back-to-back reads 0..7 with resp_ready=1: one rd handshake per cycle; eight responses in order, consecutive cycles.
- resp_ready=0 while issuing reads: rd_ready drops after 3 accepted reads. Releasing resp_ready drains 3 entries in order, then reads resume.
- wr_valid and rd_valid held high together for 4 cycles: grants alternate W,R,W,R and rr ends at 0.
- reset_n pulsed low with 2 responses queued:
  - resp_valid=0 asynchronously;
  - the sweep repeats;
  - a prior write @0x005 reads back 0 afterward.
